// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and constants for the radix-2 Booth multiplier
package booth_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // {QR[0], Q-1} recode pairs; 2'b11 behaves like NOP
    localparam logic [1:0] BOOTH_NOP = 2'b00;
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational Booth recode/add/arithmetic-shift iteration
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] qr_i,
    input  logic             qm1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] qr_o,
    output logic             qm1_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = a_i;
        case ({qr_i[0], qm1_i})
            BOOTH_ADD: sum = a_i + m_i;
            BOOTH_SUB: sum = a_i - m_i;
            default:   sum = a_i;
        endcase
        // shift {sum, qr, q-1} right by one, replicating the sign of sum
        a_o   = {sum[WIDTH], sum[WIDTH:1]};
        qr_o  = {sum[0], qr_i[WIDTH-1:1]};
        qm1_o = qr_i[0];
    end

endmodule

// File: rtl/booth_multiplier.sv
// rtl/booth_multiplier.sv - sequential radix-2 Booth multiplier with start/done handshake
module booth_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   M,
    input  logic [WIDTH-1:0]   Q,
    output logic [2*WIDTH-1:0] PRODUCT,
    output logic               busy,
    output logic               done
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [WIDTH-1:0]   qr_q, qr_d;
    logic               qm1_q, qm1_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     a_step;
    logic [WIDTH-1:0]   qr_step;
    logic               qm1_step;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a_i   (a_q),
        .qr_i  (qr_q),
        .qm1_i (qm1_q),
        .m_i   (m_q),
        .a_o   (a_step),
        .qr_o  (qr_step),
        .qm1_o (qm1_step)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        m_d       = m_q;
        qr_d      = qr_q;
        qm1_d     = qm1_q;
        count_d   = count_q;
        product_d = product_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // extra multiplicand/accumulator bit keeps A - (-2^(W-1)) in range
                    m_d     = {M[WIDTH-1], M};
                    a_d     = '0;
                    qr_d    = Q;
                    qm1_d   = 1'b0;
                    count_d = CW'(WIDTH);
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d     = a_step;
                qr_d    = qr_step;
                qm1_d   = qm1_step;
                count_d = count_q - 1'b1;
                if (count_q == CW'(1)) begin
                    product_d = {a_step[WIDTH-1:0], qr_step};
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            m_q       <= '0;
            qr_q      <= '0;
            qm1_q     <= 1'b0;
            count_q   <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            m_q       <= m_d;
            qr_q      <= qr_d;
            qm1_q     <= qm1_d;
            count_q   <= count_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign PRODUCT = product_q;
    assign busy    = (state_q == CALC);
    assign done    = done_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// tb/tb_booth_multiplier.sv - self-checking bench for booth_multiplier (WIDTH=4)
module tb_booth_multiplier;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] M;
    logic [3:0] Q;
    logic [7:0] PRODUCT;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    booth_multiplier #(
        .WIDTH (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .M       (M),
        .Q       (Q),
        .PRODUCT (PRODUCT),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_prod(input logic [3:0] m, input logic [3:0] q);
        int p;
        p = int'($signed(m)) * int'($signed(q));
        return p[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // called at a negedge; returns at the negedge where done is seen (lat=0 on timeout)
    task automatic do_op(input logic [3:0] m, input logic [3:0] q,
                         output int lat, output logic busy0, output logic busy_at_done);
        M = m;
        Q = q;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        busy0 = busy;
        busy_at_done = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = k;
                busy_at_done = busy;
                break;
            end
        end
    endtask

    logic [3:0] sw_m [6] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    logic [3:0] sw_q [6] = '{4'd2, 4'd3, 4'd3, 4'd4, 4'd4, 4'd5};
    logic [7:0] sw_e [6] = '{8'd4, 8'd9, 8'd12, 8'd20, 8'd24, 8'd35};
    logic [3:0] cr_m [5] = '{4'h8, 4'h8, 4'h7, 4'h0, 4'hF};
    logic [3:0] cr_q [5] = '{4'h8, 4'h7, 4'hF, 4'hB, 4'hF};
    logic [7:0] cr_e [5] = '{8'h40, 8'hC8, 8'hF9, 8'h00, 8'h01};

    initial begin
        int         lat;
        logic       b0, bd;
        int         ndone;
        logic [7:0] prod;
        int         dcyc [2];
        logic [7:0] dprod [2];
        logic [3:0] rm, rq;

        rst = 1'b1;
        start = 1'b0;
        M = '0;
        Q = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_product", PRODUCT, 8'h00);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            do_op(sw_m[i], sw_q[i], lat, b0, bd);
            check("sweep_product", PRODUCT, sw_e[i]);
            check("sweep_latency", lat, 4);
            check("sweep_busy_after_start", b0, 1'b1);
            check("sweep_busy_in_done_cycle", bd, 1'b0);
            @(posedge clk);
            @(negedge clk);
            check("sweep_done_one_cycle", done, 1'b0);
            check("sweep_product_hold", PRODUCT, sw_e[i]);
        end

        for (int i = 0; i < 5; i++) begin
            do_op(cr_m[i], cr_q[i], lat, b0, bd);
            check("corner_product", PRODUCT, cr_e[i]);
            check("corner_latency", lat, 4);
        end

        // operands change and extra starts while busy
        M = 4'd3;
        Q = 4'd5;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        M = 4'd7;
        Q = 4'd7;
        ndone = 0;
        prod = '0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = (k == 1 || k == 2);
            if (done) begin
                ndone++;
                prod = PRODUCT;
            end
        end
        check("midop_done_count", ndone, 1);
        check("midop_product", prod, 8'd15);
        check("midop_idle_after", busy, 1'b0);

        // reset two cycles into an operation
        M = 4'd6;
        Q = 4'hD;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_product", PRODUCT, 8'h00);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_product_stays", PRODUCT, 8'h00);
        do_op(4'd6, 4'hD, lat, b0, bd);
        check("after_abort_product", PRODUCT, 8'hEE);
        check("after_abort_latency", lat, 4);

        // start held high: two back-to-back operations
        M = 4'd7;
        Q = 4'd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        M = 4'h9;
        Q = 4'd7;
        ndone = 0;
        dcyc = '{0, 0};
        dprod = '{8'h00, 8'h00};
        for (int k = 1; k <= 30 && ndone < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                dcyc[ndone] = k;
                dprod[ndone] = PRODUCT;
                ndone++;
                if (ndone == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b_done_count", ndone, 2);
        check("b2b_first_latency", dcyc[0], 4);
        check("b2b_spacing", dcyc[1] - dcyc[0], 5);
        check("b2b_first_product", dprod[0], 8'd49);
        check("b2b_second_product", dprod[1], 8'hCF);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("b2b_no_third_op", busy, 1'b0);

        for (int mi = 0; mi < 16; mi++) begin
            for (int qi = 0; qi < 16; qi++) begin
                rm = 4'(mi);
                rq = 4'(qi);
                do_op(rm, rq, lat, b0, bd);
                check("exhaustive_product", PRODUCT, ref_prod(rm, rq));
                check("exhaustive_latency", lat, 4);
            end
        end

        for (int i = 0; i < 32; i++) begin
            rm = 4'($urandom_range(0, 15));
            rq = 4'($urandom_range(0, 15));
            do_op(rm, rq, lat, b0, bd);
            check("random_product", PRODUCT, ref_prod(rm, rq));
            check("random_latency", lat, 4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_multiplier.md
# booth_multiplier

Sequential radix-2 Booth multiplier for two's-complement operands. It captures a signed multiplicand `M` and multiplier `Q` on a `start` pulse and retires one Booth recode/add/shift step per clock. It then presents the full-width signed `PRODUCT` with a one-cycle `done` strobe. It is a standalone arithmetic block driven by a simple start/done handshake from a controlling FSM or testbench.

## Interface
- `WIDTH`, default 4: operand width in bits (≥2); product is 2·WIDTH bits.
- `clk`  input  1  single clock; all state changes on rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `start`  input  1  request; sampled only while idle.
- `M`  input  WIDTH  signed multiplicand (two's complement).
- `Q`  input  WIDTH  signed multiplier (two's complement).
- `PRODUCT`  output  2·WIDTH  signed result M·Q, registered.
- `busy`  output  1  high while an operation is in progress.
- `done`  output  1  one-cycle pulse when `PRODUCT` is updated.

## Operation
- States: IDLE, CALC.
- IDLE + `start`=1 at edge E0:
  - Latch M into an internal WIDTH+1-bit sign-extended multiplicand register.
  - Clear accumulator A (WIDTH+1 bits); load QR=Q; clear Q₋₁=0; set count=WIDTH.
  - Go to CALC.
- CALC, each edge, one step:
  - Pair {QR[0],Q₋₁}: 01 → A=A+M; 10 → A=A−M; 00/11 → no add.
  - Arithmetic shift right of {A,QR,Q₋₁} by one; A MSB is replicated.
  - count decrements.
- When the step with count=1 executes, at the same edge:
  - PRODUCT ← lower 2·WIDTH bits of the shifted {A,QR}.
  - Assert `done` for the next cycle; return to IDLE.
- Arithmetic: A is WIDTH+1 bits so that A−M with M=−2^(WIDTH−1) cannot overflow. The result is exact for all operand pairs, including (−2^(W−1))·(−2^(W−1)) = +2^(2W−2).
- `M`/`Q` changes after E0 are ignored until the next accepted start.
- `start` while busy is ignored; it is not queued.
- `start` held high continuously: a new operation is accepted on the first idle edge, i.e. the edge after `done` rises.
- PRODUCT holds its last value until the next completion.
- Reset: state←IDLE, PRODUCT←0, busy←0, done←0, and all internal registers are cleared. Reset mid-operation aborts with no `done` and leaves PRODUCT at 0. Reset has priority over `start`.

## Timing
- Latency: `done` and the new PRODUCT are visible in the cycle following edge E_WIDTH, which is WIDTH clocks after the start edge E0 (4 clocks for the default).
- `busy` is high in the cycles after E0 … E_(WIDTH−1), and low in the `done` cycle.
- `done` is high for exactly one cycle per accepted operation.
- Throughput: one operation per WIDTH+1 clocks with back-to-back starts.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `booth_pkg`:
  - state enum {IDLE, CALC};
  - default WIDTH constant;
  - Booth pair encoding constants (NOP, ADD, SUB).
- Sub-module `booth_step`: purely combinational, one iteration. Inputs A, QR, Q₋₁, M; outputs the next A, QR, Q₋₁ after add/sub and the arithmetic shift.
- Top level holds the FSM, counter, operand/result registers and handshake.

## Test plan
- Positive sweep (WIDTH=4), each with one start pulse and a wait for `done`: 2·2 → 8'd4; 3·3 → 9; 4·3 → 12; 5·4 → 20; 6·4 → 24; 7·5 → 35. `done` occurs 4 clocks after each start edge.
- Signed corners: −8·−8 → 8'h40 (64); −8·7 → 8'hC8 (−56); 7·−1 → 8'hF9 (−7); 0·−5 → 0; −1·−1 → 1.
- Operand change mid-operation: start 3·5, then drive M=7, Q=7 on the next cycle → PRODUCT=15. `start` pulses during busy are ignored: exactly one `done`.
- Reset mid-operation: assert `rst` 2 cycles after start → no `done`, PRODUCT=0, busy=0. A following start 6·−3 → 8'hEE (−18).
- Back-to-back: `start` held high with operands 7·7 then −7·7 → two `done` pulses 5 clocks apart, with PRODUCT 49 then 8'hCF (−49).
- Exhaustive: all 256 operand pairs compared against a signed reference product.
